ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands, funct3 and rd captured by ID/EX.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle.
- Raises stall_o so the ID/EX enable is held low until the result is ready.

Parameters:
- datawidth, 32, operand/result width; the RV32M semantics below are defined for 32 only.
- regindex, 5, width of the destination register index.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- start_i  input  1  ID/EX holds a valid M-extension instruction.
- flush_i  input  1  kill the in-flight operation (branch redirect/trap).
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  input  datawidth  operand A (dividend / multiplicand).
- rs2_i  input  datawidth  operand B (divisor / multiplier).
- rd_i  input  regindex  destination register index.
- result_o  output  datawidth  completed result.
- rd_o  output  regindex  destination index of the completed result.
- done_o  output  1  one-cycle pulse: result_o/rd_o valid; EX/MEM captures and writes back.
- busy_o  output  1  state != IDLE.
- stall_o  output  1  hold IF/ID and ID/EX (drive their en low).

Behaviour:
- Reset: rst sampled high forces state IDLE and counter 0, and clears result_o, rd_o, done_o and busy_o to 0. This holds from any state, including mid-CALC; the in-flight operation is discarded.
- States are IDLE, CALC and DONE.
  - IDLE with start_i=1 and flush_i=0, at edge N: capture op, rd and the operands; the inputs are ignored thereafter.
    - Special case (DIV/DIVU/REM/REMU with rs2=0, or DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): go straight to DONE.
    - Otherwise: go to CALC with counter 0.
  - CALC: one iteration per edge, counter increments. At the edge where counter=31 (edge N+32), finalize and go to DONE.
  - DONE: done_o=1 for exactly this cycle, then IDLE on the next edge unconditionally.
- Latency:
  - Normal ops: done_o high in the cycle after edge N+32, i.e. 33 cycles after the start cycle.
  - Special cases: done_o high in the cycle after edge N.
- stall_o (combinational):
  - stall_o = !flush_i & ((state==IDLE & start_i) | state==CALC).
  - stall_o is low in DONE, so ID/EX advances on the DONE edge.
  - start_i seen during CALC or DONE never starts a new operation.
- Multiply: shift-add on operand magnitudes with a 64-bit accumulator; the sign is applied at finalize.
  - MUL: low 32 bits.
  - MULH: high 32 bits, signed×signed.
  - MULHSU: high 32 bits, rs1 signed × rs2 unsigned.
  - MULHU: high 32 bits, unsigned×unsigned.
- Divide: restoring division on magnitudes.
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - DIVU/REMU are unsigned.
- Special-case results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = rs1.
  - Signed overflow: quotient 0x80000000, remainder 0.
- Output hold: result_o and rd_o update only when entering DONE and hold their last values otherwise. done_o is the only validity qualifier.
- Flush: flush_i=1 forces IDLE on the next edge from any state.
  - No done_o is produced for the killed operation; a flush during DONE suppresses done_o in that cycle.
  - result_o and rd_o are unchanged.
  - Flush together with start_i in IDLE: the operation is not accepted.
  - rst has priority over flush_i.
- Back-to-back ops: a new start_i is accepted in the IDLE cycle that follows DONE.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> stall_o high for 33 cycles; done_o one cycle 33 cycles after start; result_o=0xFFFFFFEB, rd_o=5.
- High products:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100%7 -> 2.
- Special cases, each with done_o one cycle after start and stall_o high only in the start cycle:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- flush_i pulsed at CALC counter=10 -> no done_o; busy_o=0 next cycle; an immediate new DIVU 9/3 completes with result_o=3.
- rst asserted at CALC counter=20 -> next cycle result_o=0, rd_o=0, done_o=0, busy_o=0, stall_o=0 with start_i low; no done_o ever appears for the aborted op.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// It computes one bit per cycle: shift-add multiply and restoring divide,
// both on operand magnitudes, with the result sign applied at the end.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start_i, flush_i    ID/EX holds an M-op / kill the in-flight op
//   op_i, rs1_i, rs2_i  funct3 and operands, captured when an op is accepted
//   rd_i                destination index, captured when an op is accepted
//   result_o, rd_o      completed result and its destination (held between ops)
//   done_o              one-cycle valid pulse for result_o/rd_o
//   busy_o, stall_o     not idle / hold IF/ID and ID/EX
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | one multiply/divide iteration per cycle, cnt_q = iteration index
// DONE  | result_o/rd_o valid, done_o high (unless flushed)
module ex_muldiv_unit #(
  parameter int datawidth = 32,
  parameter int regindex  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic [2:0]           op_i,
  input  logic [datawidth-1:0] rs1_i,
  input  logic [datawidth-1:0] rs2_i,
  input  logic [regindex-1:0]  rd_i,
  output logic [datawidth-1:0] result_o,
  output logic [regindex-1:0]  rd_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 stall_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DW = datawidth;
  localparam int CW = $clog2(datawidth);
  localparam logic [CW-1:0] CNT_LAST = CW'(datawidth - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [2*DW-1:0] acc_q, acc_d;   // product accumulator, or remainder in low half
  logic [2*DW-1:0] opa_q, opa_d;   // shifting multiplicand, or divisor in low half
  logic [DW-1:0]   opb_q, opb_d;   // multiplier shifting right, or dividend/quotient
  logic [regindex-1:0] rd_q, rd_d;
  logic [DW-1:0]   result_q, result_d;
  logic [regindex-1:0] rdo_q, rdo_d;

  logic            a_sgn, b_sgn, sa, sb;
  logic [DW-1:0]   mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [DW-1:0]   spec_res;

  logic [2*DW-1:0] mul_sum, mul_sum_s;
  logic [DW:0]     div_shift, div_trial;
  logic            div_bit;
  logic [DW-1:0]   rem_next, quot_next, div_val, div_val_s;
  logic [DW-1:0]   final_res;

  // Operand signedness by funct3: MULH both, MULHSU rs1 only, DIV/REM both.
  assign a_sgn = (op_i == 3'b001) | (op_i == 3'b010) | (op_i == 3'b100) | (op_i == 3'b110);
  assign b_sgn = (op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110);
  assign sa    = a_sgn & rs1_i[DW-1];
  assign sb    = b_sgn & rs2_i[DW-1];
  assign mag_a = sa ? -rs1_i : rs1_i;
  assign mag_b = sb ? -rs2_i : rs2_i;

  assign div_zero = op_i[2] & (rs2_i == '0);
  assign div_ovf  = op_i[2] & ~op_i[0] & (rs1_i == {1'b1, {(DW-1){1'b0}}}) & (rs2_i == '1);
  assign spec_res = div_zero ? (op_i[1] ? rs1_i : '1)
                             : (op_i[1] ? '0 : {1'b1, {(DW-1){1'b0}}});

  assign mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
  assign mul_sum_s = neg_q ? -mul_sum : mul_sum;

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign div_shift = {acc_q[DW-1:0], opb_q[DW-1]};
  assign div_trial = div_shift - {1'b0, opa_q[DW-1:0]};
  assign div_bit   = ~div_trial[DW];
  assign rem_next  = div_bit ? div_trial[DW-1:0] : div_shift[DW-1:0];
  assign quot_next = {opb_q[DW-2:0], div_bit};
  assign div_val   = op_q[1] ? rem_next : quot_next;
  assign div_val_s = neg_q ? -div_val : div_val;

  assign final_res = op_q[2]             ? div_val_s :
                     (op_q[1:0] == 2'b00) ? mul_sum_s[DW-1:0] : mul_sum_s[2*DW-1:DW];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rd_d     = rd_q;
    result_d = result_q;
    rdo_d    = rdo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          rd_d  = rd_i;
          cnt_d = '0;
          // Remainder follows the dividend sign; everything else is sa^sb.
          neg_d = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);
          acc_d = '0;
          if (div_zero || div_ovf) begin
            state_d  = ST_DONE;
            result_d = spec_res;
            rdo_d    = rd_i;
          end else begin
            state_d = ST_CALC;
            if (op_i[2]) begin
              opa_d = {{DW{1'b0}}, mag_b};
              opb_d = mag_a;
            end else begin
              opa_d = {{DW{1'b0}}, mag_a};
              opb_d = mag_b;
            end
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          acc_d = {{DW{1'b0}}, rem_next};
          opb_d = quot_next;
        end else begin
          acc_d = mul_sum;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          result_d = final_res;
          rdo_d    = rd_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A killed op must leave the visible outputs untouched.
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rdo_d    = rdo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rdo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rdo_q    <= rdo_d;
    end
  end

  assign result_o = result_q;
  assign rd_o     = rdo_q;
  assign done_o   = (state_q == ST_DONE) & ~flush_i;
  assign busy_o   = (state_q != ST_IDLE);
  assign stall_o  = ~flush_i & (((state_q == ST_IDLE) & start_i) | (state_q == ST_CALC));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit with hand-computed expectations.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        done_o, busy_o, stall_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.datawidth(32), .regindex(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .result_o(result_o), .rd_o(rd_o), .done_o(done_o),
    .busy_o(busy_o), .stall_o(stall_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat, stalls;
    logic got;
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1;
    #1;
    stalls = stall_o ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) got = 1'b1;
      else if (stall_o) stalls++;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_stall_cycles"}, stalls, exp_lat);
      chk({tag, "_result"}, result_o, exp);
      chk({tag, "_rd"}, 32'(rd_o), 32'(rd));
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] held;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'b000; rs1_i = '0; rs2_i = '0; rd_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result_o, 32'h0);
    chk("rst_rd", 32'(rd_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33);
    run_op("div0",   3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h0,        1);

    // start together with flush in IDLE is not accepted
    op_i = 3'b101; rs1_i = 32'd9; rs2_i = 32'd3; rd_i = 5'd3;
    start_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("flush_start_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", 32'(busy_o), 32'd0);

    // flush during DONE suppresses the pulse
    op_i = 3'b100; rs1_i = 32'd5; rs2_i = 32'd0; rd_i = 5'd17; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("flush_in_done", 32'(done_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_in_done_idle", 32'(busy_o), 32'd0);

    // flush mid-CALC at counter 10
    held = result_o;
    op_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd20; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_calc_busy", 32'(busy_o), 32'd0);
    chk("flush_calc_done", 32'(done_o), 32'd0);
    chk("flush_calc_result_held", result_o, held);
    run_op("divu_after_flush", 3'b101, 32'd9, 32'd3, 5'd21, 32'd3, 33);

    // reset mid-CALC at counter 20
    op_i = 3'b000; rs1_i = 32'd123; rs2_i = 32'd456; rd_i = 5'd22; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_calc_result", result_o, 32'h0);
    chk("rst_calc_rd", 32'(rd_o), 32'h0);
    chk("rst_calc_done", 32'(done_o), 32'h0);
    chk("rst_calc_busy", 32'(busy_o), 32'h0);
    chk("rst_calc_stall", 32'(stall_o), 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) n++;
    end
    chk("rst_calc_no_done", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
